// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 slave RAM with independent read and write burst engines
// sharing one word-addressed array. Full-width beats only. FIXED, INCR and WRAP
// bursts are supported, with byte strobes on writes.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   s_axi_aw* (id/addr/len/burst)     write address channel, valid/ready
//   s_axi_w*  (data/strb/last)        write data channel, valid/ready
//   s_axi_b*  (id/resp)               write response channel, valid/ready
//   s_axi_ar* (id/addr/len/burst)     read address channel, valid/ready
//   s_axi_r*  (id/data/resp/last)     read data channel, valid/ready
module axi_burst_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int unsigned IDX_LSB = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W   = ADDR_WIDTH - IDX_LSB;
  localparam int unsigned DEPTH   = 1 << IDX_W;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Sub-word address bits carry no meaning for full-width beats.
  if (IDX_LSB > 0) begin : g_lsb
    logic w_unused_lsb;
    assign w_unused_lsb = ^{s_axi_awaddr[IDX_LSB-1:0], s_axi_araddr[IDX_LSB-1:0]};
  end

  // Next word index; WRAP keeps the low log2(len+1) bits cycling inside the aligned block.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [7:0] len, input logic [1:0] burst);
    logic [IDX_W-1:0] inc, mask, res;
    inc  = idx + IDX_W'(1);
    mask = IDX_W'(len);
    res  = inc;
    if (burst == BURST_FIXED)
      res = idx;
    else if (burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      res = (idx & ~mask) | (inc & mask);
    return res;
  endfunction

  // ---------------- write engine ----------------
  wstate_t             r_wstate, w_wstate_nxt;
  logic                r_awready, r_wready, r_bvalid, r_werr;
  logic [ID_WIDTH-1:0] r_awid, r_bid;
  logic [1:0]          r_bresp, r_wburst;
  logic [IDX_W-1:0]    r_widx;
  logic [7:0]          r_wlen, r_wcnt;
  logic                w_aw_hs, w_w_hs, w_wfinal, w_werr_nxt;

  // Write next-state and handshake decode.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    w_wfinal     = 1'b0;
    w_werr_nxt   = r_werr;
    case (r_wstate)
      W_IDLE: if (s_axi_awvalid && r_awready) begin
        w_aw_hs      = 1'b1;
        w_wstate_nxt = W_DATA;
      end
      W_DATA: if (s_axi_wvalid && r_wready) begin
        w_w_hs     = 1'b1;
        w_wfinal   = (r_wcnt == r_wlen);
        // Beat count ends the burst; a wlast disagreeing with it only flags an error.
        w_werr_nxt = r_werr | (s_axi_wlast != w_wfinal);
        if (w_wfinal) w_wstate_nxt = W_RESP;
      end
      W_RESP: if (r_bvalid && s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write state, channel flags and burst bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_awid    <= '0;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wburst  <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_awid   <= s_axi_awid;
        r_widx   <= s_axi_awaddr[ADDR_WIDTH-1:IDX_LSB];
        r_wlen   <= s_axi_awlen;
        r_wburst <= s_axi_awburst;
        r_wcnt   <= '0;
        r_werr   <= 1'b0;
      end
      if (w_w_hs) begin
        r_widx <= next_idx(r_widx, r_wlen, r_wburst);
        r_wcnt <= r_wcnt + 8'd1;
        r_werr <= w_werr_nxt;
        if (w_wfinal) begin
          r_bid   <= r_awid;
          r_bresp <= (w_werr_nxt || r_wburst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // RAM byte writes; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_w_hs && r_wburst != BURST_RSVD) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++)
        if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;

  // ---------------- read engine ----------------
  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0]   r_arid, r_rid;
  logic [1:0]            r_rburst, r_rresp;
  logic [IDX_W-1:0]      r_ridx;
  logic [7:0]            r_rlen;
  logic [8:0]            r_rleft;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_ar_hs, w_rload, w_rtake;

  // Read next-state; the output register refills whenever it is empty or being drained.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_hs      = 1'b0;
    w_rload      = 1'b0;
    w_rtake      = 1'b0;
    case (r_rstate)
      R_IDLE: if (s_axi_arvalid && r_arready) begin
        w_ar_hs      = 1'b1;
        w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        w_rtake = r_rvalid && s_axi_rready;
        w_rload = (r_rleft != 9'd0) && (!r_rvalid || s_axi_rready);
        if (w_rtake && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read state and R output register; RAM read sees pre-write data in a shared cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= '0;
      r_rdata   <= '0;
      r_arid    <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rburst  <= '0;
      r_rleft   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_arid   <= s_axi_arid;
        r_ridx   <= s_axi_araddr[ADDR_WIDTH-1:IDX_LSB];
        r_rlen   <= s_axi_arlen;
        r_rburst <= s_axi_arburst;
        r_rleft  <= 9'(s_axi_arlen) + 9'd1;
      end
      if (w_rload) begin
        r_rvalid <= 1'b1;
        r_rdata  <= (r_rburst == BURST_RSVD) ? '0 : r_mem[r_ridx];
        r_rresp  <= (r_rburst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
        r_rid    <= r_arid;
        r_rlast  <= (r_rleft == 9'd1);
        r_rleft  <= r_rleft - 9'd1;
        r_ridx   <= next_idx(r_ridx, r_rlen, r_rburst);
      end else if (w_rtake) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: randomized and directed bursts against a word-array model of the RAM.
module tb_axi_burst_ram;
  localparam int DEPTH = 1 << 14;

  logic        clk, rst_n;
  logic [7:0]  s_axi_awid, s_axi_awlen, s_axi_arid, s_axi_arlen;
  logic [15:0] s_axi_awaddr, s_axi_araddr;
  logic [1:0]  s_axi_awburst, s_axi_arburst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_burst_ram dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  id;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] mdl [DEPTH];
  rexp_t       rexp_q[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          rr_mode = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Word visited on beat k, from the burst rules stated as plain arithmetic.
  function automatic int exp_idx(input int start, input int len, input int burst, input int k);
    int n;
    n = len + 1;
    if (burst == 0) return start;
    if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16))
      return (start - (start % n)) + ((start % n) + k) % n;
    return (start + k) % DEPTH;
  endfunction

  // rready driver: always high, random, or a fixed 1-0-1 style pattern.
  initial begin
    logic [6:0] pat;
    int         p;
    pat = 7'b1011001;
    p = 0;
    s_axi_rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: s_axi_rready = 1'b1;
        1: s_axi_rready = ($urandom_range(0, 2) != 0);
        default: begin
          s_axi_rready = pat[p];
          p = (p + 1) % 7;
        end
      endcase
    end
  end

  // Per-cycle R check: the head of the expected queue must be on the bus while rvalid is high.
  initial begin
    rexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && s_axi_rvalid) begin
        if (rexp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL r_unexpected: rvalid with no beat pending, rdata=0x%08h at %0t", s_axi_rdata, $time);
        end else begin
          e = rexp_q[0];
          nchk++;
          if (s_axi_rdata !== e.d || s_axi_rid !== e.id || s_axi_rresp !== e.resp || s_axi_rlast !== e.last) begin
            nerr++;
            $display("FAIL r_beat: got data=0x%08h id=0x%02h resp=%0d last=%0d expected data=0x%08h id=0x%02h resp=%0d last=%0d at %0t",
                     s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, e.d, e.id, e.resp, e.last, $time);
          end
          if (s_axi_rready) void'(rexp_q.pop_front());
        end
      end
    end
  end

  // Drive tasks enter and leave 1 time unit after a rising edge.
  task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_axi_awready && t < 50);
    chk("aw_handshake", 32'(s_axi_awready), 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    int t;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last;
    s_axi_wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_axi_wready && t < 50);
    chk("w_handshake", 32'(s_axi_wready), 32'd1);
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
  endtask

  task automatic b_check(input logic [7:0] id, input logic [1:0] resp);
    int d;
    @(negedge clk);
    chk("b_valid_rise", 32'(s_axi_bvalid), 32'd1);
    chk("b_wready_low", 32'(s_axi_wready), 32'd0);
    chk("b_id", 32'(s_axi_bid), 32'(id));
    chk("b_resp", 32'(s_axi_bresp), 32'(resp));
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk);
      chk("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
      chk("b_hold_id", 32'(s_axi_bid), 32'(id));
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    @(negedge clk);
    chk("b_valid_drop", 32'(s_axi_bvalid), 32'd0);
    chk("aw_ready_again", 32'(s_axi_awready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int err_beat);
    int start, idx;
    aw_send(id, addr, len, burst);
    for (int k = 0; k <= int'(len); k++)
      w_beat(wd[k], ws[k], (k == int'(len)) ^ (k == err_beat));
    b_check(id, (err_beat >= 0 || burst == 2'd3) ? 2'd2 : 2'd0);
    if (burst != 2'd3) begin
      start = int'(addr) >> 2;
      for (int k = 0; k <= int'(len); k++) begin
        idx = exp_idx(start, int'(len), int'(burst), k);
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) mdl[idx][b*8 +: 8] = wd[k][b*8 +: 8];
      end
    end
  endtask

  task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit prefilled);
    rexp_t e;
    int    start, t;
    if (!prefilled) begin
      start = int'(addr) >> 2;
      for (int k = 0; k <= int'(len); k++) begin
        e.d    = (burst == 2'd3) ? 32'd0 : mdl[exp_idx(start, int'(len), int'(burst), k)];
        e.id   = id;
        e.resp = (burst == 2'd3) ? 2'd2 : 2'd0;
        e.last = (k == int'(len));
        rexp_q.push_back(e);
      end
    end
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_axi_arready && t < 50);
    chk("ar_handshake", 32'(s_axi_arready), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("r_latency_n1", 32'(s_axi_rvalid), 32'd0);
    @(negedge clk);
    chk("r_latency_n2", 32'(s_axi_rvalid), 32'd1);
    #1;
    t = 0;
    while (rexp_q.size() != 0 && t < 1000) begin @(negedge clk); #1; t++; end
    chk("r_drained", 32'(rexp_q.size()), 32'd0);
    @(negedge clk);
    chk("ar_ready_again", 32'(s_axi_arready), 32'd1);
    chk("r_valid_idle", 32'(s_axi_rvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    nerr++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rexp_t e;
    int    wexp [4];
    int    len, bsel, a, eb;
    logic [1:0] bt;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
    rst_n = 1'b0;
    s_axi_awvalid = 0; s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awburst = 0;
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arburst = 0;

    // Reset state, then ready one edge after release.
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_awready", 32'(s_axi_awready), 32'd1);
    chk("rel_arready", 32'(s_axi_arready), 32'd1);
    @(posedge clk); #1;

    // Preload bytes 0x000-0x7FF so every later read hits known data.
    for (int base = 0; base < 'h800; base += 64) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(8'($urandom), 16'(base), 8'd15, 2'd1, -1);
    end

    // INCR len=3 at 0x10, data 1..4.
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    do_write(8'h5A, 16'h0010, 8'd3, 2'd1, -1);
    for (int k = 0; k < 4; k++) chk("pin_incr_model", mdl[4 + k], 32'(k + 1));
    do_read(8'hA5, 16'h0010, 8'd3, 2'd1, 1'b0);

    // WRAP len=3 from 0x18 visits 0x18,0x1C,0x10,0x14.
    for (int k = 0; k < 4; k++) begin wd[k] = 32'h10 + 32'(4 * k); ws[k] = 4'hF; end
    do_write(8'h11, 16'h0010, 8'd3, 2'd1, -1);
    wexp = '{6, 7, 4, 5};
    for (int k = 0; k < 4; k++) chk("pin_wrap_idx", 32'(exp_idx(6, 3, 2, k)), 32'(wexp[k]));
    wexp = '{'h18, 'h1C, 'h10, 'h14};
    for (int k = 0; k < 4; k++) begin
      e.d = 32'(wexp[k]); e.id = 8'h22; e.resp = 2'd0; e.last = (k == 3);
      rexp_q.push_back(e);
    end
    do_read(8'h22, 16'h0018, 8'd3, 2'd2, 1'b1);

    // FIXED len=2 at 0x40: last beat wins.
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    do_write(8'h33, 16'h0040, 8'd2, 2'd0, -1);
    chk("pin_fixed_model", mdl['h10], 32'hC);
    do_read(8'h34, 16'h0040, 8'd0, 2'd1, 1'b0);

    // Strobe 0101 over a zeroed word.
    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(8'h40, 16'h0080, 8'd0, 2'd1, -1);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0101;
    do_write(8'h41, 16'h0080, 8'd0, 2'd1, -1);
    chk("pin_strb_model", mdl['h20], 32'h00FF_00FF);
    do_read(8'h42, 16'h0080, 8'd0, 2'd1, 1'b0);

    // 8-beat read with rready stalling.
    rr_mode = 2;
    do_read(8'h50, 16'h0100, 8'd7, 2'd1, 1'b0);
    rr_mode = 0;

    // wlast early on beat 2 of 4, then wlast missing on the final beat.
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(8'h60, 16'h0140, 8'd3, 2'd1, 1);
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(8'h61, 16'h0150, 8'd3, 2'd1, 3);
    do_read(8'h62, 16'h0140, 8'd7, 2'd1, 1'b0);

    // Reserved burst: no write, zero data, SLVERR.
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(8'h70, 16'h0300, 8'd3, 2'd3, -1);
    do_read(8'h71, 16'h0300, 8'd3, 2'd3, 1'b0);
    do_read(8'h72, 16'h0300, 8'd3, 2'd1, 1'b0);

    // INCR across the top of the address space wraps to word 0.
    for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(8'h80, 16'hFFF0, 8'd7, 2'd1, -1);
    do_read(8'h81, 16'hFFF0, 8'd7, 2'd1, 1'b0);

    // Reset in the middle of a write burst.
    aw_send(8'h90, 16'h0200, 8'd3, 2'd1);
    w_beat(32'h1111_1111, 4'hF, 1'b0);
    w_beat(32'h2222_2222, 4'hF, 1'b0);
    mdl['h80] = 32'h1111_1111;
    mdl['h81] = 32'h2222_2222;
    chk("mid_wready", 32'(s_axi_wready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_awready", 32'(s_axi_awready), 32'd0);
    chk("mid_rst_wready", 32'(s_axi_wready), 32'd0);
    chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_awready", 32'(s_axi_awready), 32'd1);
    chk("mid_rel_bvalid", 32'(s_axi_bvalid), 32'd0);
    @(posedge clk); #1;
    wd[0] = 32'h3333_3333; wd[1] = 32'h4444_4444; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(8'h91, 16'h0208, 8'd1, 2'd1, -1);
    do_read(8'h92, 16'h0200, 8'd3, 2'd1, 1'b0);

    // Random serial traffic with random rready.
    rr_mode = 1;
    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, 'h7BF);
      len = $urandom_range(0, 15);
      bsel = $urandom_range(0, 7);
      bt = (bsel < 2) ? 2'd0 : (bsel < 5) ? 2'd1 : (bsel < 7) ? 2'd2 : 2'd3;
      if (bt == 2'd2 && $urandom_range(0, 1) == 1) len = (1 << $urandom_range(1, 4)) - 1;
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
        eb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        do_write(8'($urandom), 16'(a), 8'(len), bt, eb);
      end else begin
        do_read(8'($urandom), 16'(a), 8'(len), bt, 1'b0);
      end
    end

    // Concurrent write and read on disjoint halves of the window.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      fork
        do_write(8'($urandom), 16'($urandom_range(0, 'h3BF)), 8'($urandom_range(0, 15)), 2'($urandom_range(0, 2)), -1);
        do_read(8'($urandom), 16'($urandom_range('h400, 'h7BF)), 8'($urandom_range(0, 15)), 2'($urandom_range(0, 2)), 1'b0);
      join
    end
    rr_mode = 0;
    do_read(8'hEE, 16'h0000, 8'd15, 2'd1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
